// File: rtl/cpu_pipe_ctrl_unit_pkg.sv
// Shared control-path types for the RV32I pipeline: opcodes, ALU selects,
// branch funct3 codes and the per-stage control bundle.
package pkg_cpu_typedefs;

    localparam int ALU_SEL_PKG_W = 4;

    typedef enum logic [ALU_SEL_PKG_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_sel_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_I_TYPE = 7'b0010011;
    localparam logic [6:0] OPC_AUI_PC = 7'b0010111;
    localparam logic [6:0] OPC_S_TYPE = 7'b0100011;
    localparam logic [6:0] OPC_R_TYPE = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_B_TYPE = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_J_TYPE = 7'b1101111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic       jmp;
        logic       bra;
        logic       jalr;
        logic [1:0] alu_a_src;
        logic       alu_b_src;
        alu_sel_e   alu_op_sel;
        logic [2:0] funct3;
        logic       mem_wr_en;
        logic [1:0] result_src;
        logic       regfl_wr_en;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t BUBBLE = '0;

endpackage

// File: rtl/cpu_pipe_ctrl_unit_alu_decoder.sv
// Combinational ALU operation decoder (alu_op class + funct3/funct7[5] -> select).
module cpu_alu_decoder
    import pkg_cpu_typedefs::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       opc_b5,
    input  logic       f7b5,
    output alu_sel_e   alu_op_sel
);

    always_comb begin
        alu_op_sel = ALU_ADD;
        case (alu_op)
            2'b00: alu_op_sel = ALU_ADD;
            2'b01: alu_op_sel = ALU_SUB;
            2'b10: begin
                case (funct3)
                    // funct7[5] only selects SUB for register-register forms
                    3'b000:  alu_op_sel = (opc_b5 & f7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_op_sel = ALU_SLL;
                    3'b010:  alu_op_sel = ALU_SLT;
                    3'b011:  alu_op_sel = ALU_SLTU;
                    3'b100:  alu_op_sel = ALU_XOR;
                    3'b101:  alu_op_sel = f7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_op_sel = ALU_OR;
                    default: alu_op_sel = ALU_AND;
                endcase
            end
            default: alu_op_sel = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/cpu_pipe_ctrl_unit.sv
// Pipelined RV32I control unit: ID decode, then EX / MEM(xMEM_STAGES) / WB bundles.
// Optional illegal-instruction reporting under CPU_CTRL_ILLEGAL_INSTR_EN.
module cpu_pipe_ctrl_unit
    import pkg_cpu_typedefs::*;
#(
    parameter int MEM_STAGES = 1,
    parameter int ALU_SEL_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pipe_en,
    input  logic                 flush_ex,
    input  logic                 id_valid,
    input  logic [6:0]           id_opc,
    input  logic [2:0]           id_funct3,
    input  logic                 id_funct7_b5,
    output logic [2:0]           id_imd_src,
    input  logic                 ex_zero,
    input  logic                 ex_neg,
    input  logic                 ex_ovf,
    input  logic                 ex_carry,
    output logic [1:0]           ex_alu_a_src,
    output logic                 ex_alu_b_src,
    output logic [ALU_SEL_W-1:0] ex_alu_op_sel,
    output logic                 ex_pc_src,
    output logic                 ex_jalr,
    output logic [1:0]           ex_result_src,
    output logic                 ex_regfl_wr_en,
    output logic                 mem_wr_en,
    output logic [2:0]           mem_funct3,
    output logic                 mem_regfl_wr_en,
    output logic [1:0]           mem_result_src,
    output logic                 wb_regfl_wr_en,
    output logic [1:0]           wb_result_src
`ifdef CPU_CTRL_ILLEGAL_INSTR_EN
   ,output logic                 ex_illegal,
    output logic                 illegal_sticky
`endif
);

    ctrl_bundle_t id_dec, id_next, ex_q;
    ctrl_bundle_t mem_pipe [MEM_STAGES];
    logic [1:0]   id_alu_op;
    logic         id_bad, id_illegal, br_taken;
    logic         wb_wr_q;
    logic [1:0]   wb_res_q;
    alu_sel_e     id_alu_sel;

    always_comb begin
        id_dec        = BUBBLE;
        id_dec.funct3 = id_funct3;
        id_alu_op     = 2'b00;
        id_imd_src    = 3'b000;
        id_bad        = 1'b0;
        case (id_opc)
            OPC_LOAD: begin
                id_dec.alu_b_src   = 1'b1;
                id_dec.result_src  = 2'b01;
                id_dec.regfl_wr_en = 1'b1;
                id_bad = (id_funct3 == 3'b011) || (id_funct3[2:1] == 2'b11);
            end
            OPC_AUI_PC, OPC_LUI: begin
                id_dec.alu_a_src   = id_opc[5] ? 2'b10 : 2'b11;
                id_dec.alu_b_src   = 1'b1;
                id_dec.regfl_wr_en = 1'b1;
                id_imd_src         = 3'b100;
            end
            OPC_JALR: begin
                id_dec.jmp         = 1'b1;
                id_dec.jalr        = 1'b1;
                id_dec.alu_b_src   = 1'b1;
                id_dec.result_src  = 2'b10;
                id_dec.regfl_wr_en = 1'b1;
                id_bad = (id_funct3 != 3'b000);
            end
            OPC_S_TYPE: begin
                id_dec.alu_b_src = 1'b1;
                id_dec.mem_wr_en = 1'b1;
                id_imd_src       = 3'b001;
                id_bad = (id_funct3 > 3'b010);
            end
            OPC_R_TYPE: begin
                id_dec.regfl_wr_en = 1'b1;
                id_alu_op          = 2'b10;
            end
            OPC_I_TYPE: begin
                id_dec.alu_b_src   = 1'b1;
                id_dec.regfl_wr_en = 1'b1;
                id_alu_op          = 2'b10;
                // only funct7[5] is visible here; SLLI must have it clear
                id_bad = (id_funct3 == 3'b001) && id_funct7_b5;
            end
            OPC_J_TYPE: begin
                id_dec.jmp         = 1'b1;
                id_dec.alu_a_src   = 2'b11;
                id_dec.alu_b_src   = 1'b1;
                id_dec.result_src  = 2'b10;
                id_dec.regfl_wr_en = 1'b1;
                id_imd_src         = 3'b011;
            end
            OPC_B_TYPE: begin
                id_dec.bra = 1'b1;
                id_imd_src = 3'b010;
                id_alu_op  = 2'b01;
                id_bad = (id_funct3[2:1] == 2'b01);
            end
            default: id_bad = 1'b1;
        endcase
    end

    cpu_alu_decoder u_alu_dec (
        .alu_op     (id_alu_op),
        .funct3     (id_funct3),
        .opc_b5     (id_opc[5]),
        .f7b5       (id_funct7_b5),
        .alu_op_sel (id_alu_sel)
    );

    assign id_illegal = id_valid & id_bad;

    always_comb begin
        id_next            = id_dec;
        id_next.alu_op_sel = id_alu_sel;
        if (!id_valid || id_bad)
            id_next = BUBBLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= BUBBLE;
            for (int i = 0; i < MEM_STAGES; i++)
                mem_pipe[i] <= BUBBLE;
            wb_wr_q  <= 1'b0;
            wb_res_q <= 2'b00;
        end else if (pipe_en) begin
            ex_q        <= flush_ex ? BUBBLE : id_next;
            mem_pipe[0] <= ex_q;
            for (int i = 1; i < MEM_STAGES; i++)
                mem_pipe[i] <= mem_pipe[i-1];
            wb_wr_q  <= mem_pipe[MEM_STAGES-1].regfl_wr_en;
            wb_res_q <= mem_pipe[MEM_STAGES-1].result_src;
        end
    end

    always_comb begin
        br_taken = 1'b0;
        case (ex_q.funct3)
            F3_BEQ:  br_taken = ex_zero;
            F3_BNE:  br_taken = !ex_zero;
            F3_BLT:  br_taken = ex_neg ^ ex_ovf;
            F3_BGE:  br_taken = !(ex_neg ^ ex_ovf);
            F3_BLTU: br_taken = !ex_carry;
            F3_BGEU: br_taken = ex_carry;
            default: br_taken = 1'b0;
        endcase
    end

    assign ex_pc_src       = ex_q.jmp | (ex_q.bra & br_taken);
    assign ex_alu_a_src    = ex_q.alu_a_src;
    assign ex_alu_b_src    = ex_q.alu_b_src;
    assign ex_alu_op_sel   = ALU_SEL_W'(ex_q.alu_op_sel);
    assign ex_jalr         = ex_q.jalr;
    assign ex_result_src   = ex_q.result_src;
    assign ex_regfl_wr_en  = ex_q.regfl_wr_en;
    assign mem_wr_en       = mem_pipe[0].mem_wr_en;
    assign mem_funct3      = mem_pipe[0].funct3;
    assign mem_regfl_wr_en = mem_pipe[0].regfl_wr_en;
    assign mem_result_src  = mem_pipe[0].result_src;
    assign wb_regfl_wr_en  = wb_wr_q;
    assign wb_result_src   = wb_res_q;

`ifdef CPU_CTRL_ILLEGAL_INSTR_EN
    logic ill_q, sticky_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else if (pipe_en) begin
            ill_q <= id_illegal & !flush_ex;
            if (id_illegal & !flush_ex)
                sticky_q <= 1'b1;
        end
    end

    assign ex_illegal     = ill_q;
    assign illegal_sticky = sticky_q;
`else
    logic unused_illegal;
    assign unused_illegal = id_illegal;
`endif

endmodule

// File: tb/tb_cpu_pipe_ctrl_unit.sv
// Scoreboard bench for cpu_pipe_ctrl_unit (MEM_STAGES = 2); expectations are
// queued per cycle by the stimulus and checked on the falling edge by a monitor.
module tb_cpu_pipe_ctrl_unit;

    logic       clk = 1'b0, rst_n = 1'b0, pipe_en = 1'b1, flush_ex = 1'b0;
    logic       id_valid = 1'b0, id_funct7_b5 = 1'b0;
    logic [6:0] id_opc = '0;
    logic [2:0] id_funct3 = '0;
    logic       ex_zero = 1'b0, ex_neg = 1'b0, ex_ovf = 1'b0, ex_carry = 1'b0;
    logic [2:0] id_imd_src, mem_funct3;
    logic [1:0] ex_alu_a_src, ex_result_src, mem_result_src, wb_result_src;
    logic [3:0] ex_alu_op_sel;
    logic       ex_alu_b_src, ex_pc_src, ex_jalr, ex_regfl_wr_en;
    logic       mem_wr_en, mem_regfl_wr_en, wb_regfl_wr_en;
`ifdef CPU_CTRL_ILLEGAL_INSTR_EN
    logic       ex_illegal, illegal_sticky;
`endif

    cpu_pipe_ctrl_unit #(.MEM_STAGES(2), .ALU_SEL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .pipe_en(pipe_en), .flush_ex(flush_ex),
        .id_valid(id_valid), .id_opc(id_opc), .id_funct3(id_funct3),
        .id_funct7_b5(id_funct7_b5), .id_imd_src(id_imd_src),
        .ex_zero(ex_zero), .ex_neg(ex_neg), .ex_ovf(ex_ovf), .ex_carry(ex_carry),
        .ex_alu_a_src(ex_alu_a_src), .ex_alu_b_src(ex_alu_b_src),
        .ex_alu_op_sel(ex_alu_op_sel), .ex_pc_src(ex_pc_src), .ex_jalr(ex_jalr),
        .ex_result_src(ex_result_src), .ex_regfl_wr_en(ex_regfl_wr_en),
        .mem_wr_en(mem_wr_en), .mem_funct3(mem_funct3),
        .mem_regfl_wr_en(mem_regfl_wr_en), .mem_result_src(mem_result_src),
        .wb_regfl_wr_en(wb_regfl_wr_en), .wb_result_src(wb_result_src)
`ifdef CPU_CTRL_ILLEGAL_INSTR_EN
       ,.ex_illegal(ex_illegal), .illegal_sticky(illegal_sticky)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int S_ALL = 0, S_IMD = 1, S_EX_A = 2, S_EX_B = 3, S_EX_ALU = 4,
                   S_PC = 5, S_EX_RES = 6, S_EX_WR = 7, S_MEM_WR = 8, S_MEM_F3 = 9,
                   S_MEM_RES = 10, S_WB_WR = 11, S_WB_RES = 12, S_ILL = 13, S_STICKY = 14;

    function automatic logic [31:0] probe(input int s);
        logic [31:0] r;
        r = '0;
        case (s)
            S_ALL: begin
                r = 32'({ex_alu_a_src, ex_alu_b_src, ex_alu_op_sel, ex_pc_src, ex_jalr,
                         ex_result_src, ex_regfl_wr_en, mem_wr_en, mem_funct3,
                         mem_regfl_wr_en, mem_result_src, wb_regfl_wr_en, wb_result_src});
`ifdef CPU_CTRL_ILLEGAL_INSTR_EN
                r = r | 32'({ex_illegal, illegal_sticky});
`endif
            end
            S_IMD:     r = 32'(id_imd_src);
            S_EX_A:    r = 32'(ex_alu_a_src);
            S_EX_B:    r = 32'(ex_alu_b_src);
            S_EX_ALU:  r = 32'(ex_alu_op_sel);
            S_PC:      r = 32'(ex_pc_src);
            S_EX_RES:  r = 32'(ex_result_src);
            S_EX_WR:   r = 32'(ex_regfl_wr_en);
            S_MEM_WR:  r = 32'(mem_wr_en);
            S_MEM_F3:  r = 32'(mem_funct3);
            S_MEM_RES: r = 32'(mem_result_src);
            S_WB_WR:   r = 32'(wb_regfl_wr_en);
            S_WB_RES:  r = 32'(wb_result_src);
`ifdef CPU_CTRL_ILLEGAL_INSTR_EN
            S_ILL:     r = 32'(ex_illegal);
            S_STICKY:  r = 32'(illegal_sticky);
`endif
            default:   r = 32'hdead_beef;
        endcase
        return r;
    endfunction

    typedef struct {
        int          c;
        int          s;
        logic [31:0] v;
        string       name;
    } exp_t;
    exp_t sb[$];

    int checks = 0, errors = 0;

    task automatic expect_at(input int c, input int s, input logic [31:0] v, input string name);
        exp_t e;
        e.c = c; e.s = s; e.v = v; e.name = name;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].c == cyc) begin
                checks++;
                if (probe(sb[i].s) !== sb[i].v) begin
                    errors++;
                    $display("FAIL %s @cyc %0d: got %0h expected %0h",
                             sb[i].name, cyc, probe(sb[i].s), sb[i].v);
                end
                sb.delete(i);
            end else if (sb[i].c < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: cycle %0d never sampled", sb[i].name, sb[i].c);
                sb.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] opc, input logic [2:0] f3, input logic f7);
        id_valid = v; id_opc = opc; id_funct3 = f3; id_funct7_b5 = f7;
    endtask

    typedef struct {
        logic       v;
        logic [6:0] opc;
        logic [2:0] f3;
        logic       f7;
        logic [3:0] fl;   // {zero, neg, ovf, carry} while this entry sits in EX
        logic [3:0] alu;
        logic       wr;
        logic       pc;
        logic [2:0] imd;
        string      nm;
    } vec_t;
    vec_t tbl[$];

    task automatic addv(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                        input logic f7, input logic [3:0] fl, input logic [3:0] alu,
                        input logic wr, input logic pc, input logic [2:0] imd, input string nm);
        vec_t e;
        e.v = v; e.opc = opc; e.f3 = f3; e.f7 = f7; e.fl = fl;
        e.alu = alu; e.wr = wr; e.pc = pc; e.imd = imd; e.nm = nm;
        tbl.push_back(e);
    endtask

    initial begin
        //    v  opc         f3      f7 flags    alu wr pc imd
        addv(1, 7'b0110011, 3'b000, 1, 4'b0000, 1, 1, 0, 3'd0, "sub");
        addv(1, 7'b0010011, 3'b101, 1, 4'b0000, 9, 1, 0, 3'd0, "srai");
        addv(1, 7'b0110011, 3'b100, 0, 4'b0000, 4, 1, 0, 3'd0, "xor");
        addv(1, 7'b0010011, 3'b011, 0, 4'b0000, 6, 1, 0, 3'd0, "sltiu");
        addv(1, 7'b0010011, 3'b000, 1, 4'b0000, 0, 1, 0, 3'd0, "addi_f7");
        addv(1, 7'b0110011, 3'b001, 0, 4'b0000, 7, 1, 0, 3'd0, "sll");
        addv(1, 7'b0110011, 3'b101, 0, 4'b0000, 8, 1, 0, 3'd0, "srl");
        addv(1, 7'b0010011, 3'b110, 0, 4'b0000, 3, 1, 0, 3'd0, "ori");
        addv(1, 7'b0110011, 3'b111, 0, 4'b0000, 2, 1, 0, 3'd0, "and");
        addv(1, 7'b0110011, 3'b010, 0, 4'b0000, 5, 1, 0, 3'd0, "slt");
        addv(1, 7'b0110111, 3'b000, 0, 4'b0000, 0, 1, 0, 3'd4, "lui");
        addv(1, 7'b1100011, 3'b110, 0, 4'b0000, 1, 0, 1, 3'd2, "bltu_nc");
        addv(1, 7'b1100011, 3'b110, 0, 4'b0001, 1, 0, 0, 3'd2, "bltu_c");
        addv(1, 7'b1100011, 3'b101, 0, 4'b0110, 1, 0, 1, 3'd2, "bge_nv");
        addv(1, 7'b1100011, 3'b100, 0, 4'b0100, 1, 0, 1, 3'd2, "blt_n");
        addv(1, 7'b1100011, 3'b000, 0, 4'b0000, 1, 0, 0, 3'd2, "beq_nz");
        addv(1, 7'b1100011, 3'b000, 0, 4'b1000, 1, 0, 1, 3'd2, "beq_z");
        addv(1, 7'b1100011, 3'b001, 0, 4'b0000, 1, 0, 1, 3'd2, "bne_nz");
        addv(1, 7'b1100011, 3'b111, 0, 4'b0001, 1, 0, 1, 3'd2, "bgeu_c");
        addv(1, 7'b1100011, 3'b010, 0, 4'b1001, 0, 0, 0, 3'd2, "b_f3_010");
        addv(1, 7'b1101111, 3'b000, 0, 4'b0000, 0, 1, 1, 3'd3, "jal");
        addv(1, 7'b1100111, 3'b000, 0, 4'b0000, 0, 1, 1, 3'd0, "jalr");
        addv(0, 7'b0110011, 3'b000, 0, 4'b0000, 0, 0, 0, 3'd0, "invalid");
        addv(1, 7'b1111111, 3'b000, 0, 4'b0000, 0, 0, 0, 3'd0, "unknown");
    end

    initial begin
        int c;
        step();
        expect_at(cyc, S_ALL, 0, "reset_all");
        step();
        rst_n = 1'b1;
        expect_at(cyc, S_ALL, 0, "release_all");
        expect_at(cyc + 1, S_ALL, 0, "first_edge_all");
        step();

`ifdef CPU_CTRL_ILLEGAL_INSTR_EN
        expect_at(cyc, S_STICKY, 0, "sticky_clear");
        drive(1, 7'b1100011, 3'b010, 0);
        {ex_zero, ex_carry} = 2'b11;
        expect_at(cyc + 1, S_ILL, 1, "ill_b010");
        expect_at(cyc + 1, S_STICKY, 1, "sticky_set");
        expect_at(cyc + 1, S_EX_WR, 0, "ill_wr");
        expect_at(cyc + 1, S_PC, 0, "ill_pc");
        expect_at(cyc + 2, S_MEM_WR, 0, "ill_memwr");
        step();
        drive(1, 7'b0010011, 3'b000, 0);
        expect_at(cyc + 1, S_ILL, 0, "ill_one_cycle");
        expect_at(cyc + 1, S_STICKY, 1, "sticky_hold");
        step();
        drive(1, 7'b0010011, 3'b001, 1);
        expect_at(cyc + 1, S_ILL, 1, "ill_slli_f7");
        expect_at(cyc + 1, S_EX_WR, 0, "ill_slli_wr");
        expect_at(cyc + 3, S_WB_WR, 0, "ill_slli_wbwr");
        step();
        drive(0, 7'b0, 3'b0, 0);
        {ex_zero, ex_carry} = 2'b00;
        step();
        step();
        step();
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].opc, tbl[i].f3, tbl[i].f7);
            if (i > 0) {ex_zero, ex_neg, ex_ovf, ex_carry} = tbl[i-1].fl;
            expect_at(cyc, S_IMD, 32'(tbl[i].imd), {tbl[i].nm, "_imd"});
            expect_at(cyc + 1, S_EX_ALU, 32'(tbl[i].alu), {tbl[i].nm, "_alu"});
            expect_at(cyc + 1, S_EX_WR, 32'(tbl[i].wr), {tbl[i].nm, "_wr"});
            expect_at(cyc + 1, S_PC, 32'(tbl[i].pc), {tbl[i].nm, "_pcsrc"});
            step();
        end
        {ex_zero, ex_neg, ex_ovf, ex_carry} = tbl[tbl.size()-1].fl;
        drive(0, 7'b0, 3'b0, 0);
        step();
        {ex_zero, ex_neg, ex_ovf, ex_carry} = 4'b0000;
        step();
        step();

        // load then flush: WB sees the load 3 cycles after its EX cycle
        drive(1, 7'b0000011, 3'b010, 0);
        step();
        c = cyc;
        expect_at(c, S_EX_RES, 1, "load_ex_res");
        expect_at(c, S_EX_WR, 1, "load_ex_wr");
        expect_at(c + 1, S_MEM_RES, 1, "load_mem_res");
        expect_at(c + 2, S_WB_RES, 0, "load_wb_early");
        expect_at(c + 3, S_WB_RES, 1, "load_wb_res");
        expect_at(c + 3, S_WB_WR, 1, "load_wb_wr");
        expect_at(c + 4, S_WB_RES, 0, "flushed_wb");
        drive(1, 7'b0010011, 3'b000, 0);
        flush_ex = 1'b1;
        expect_at(c + 1, S_EX_WR, 0, "flush_ex_wr");
        expect_at(c + 1, S_EX_B, 0, "flush_ex_b");
        step();
        flush_ex = 1'b0;
        drive(0, 7'b0, 3'b0, 0);
        repeat (4) step();

        // freeze with JAL in EX and the load in WB
        drive(1, 7'b0000011, 3'b010, 0);
        step();
        drive(0, 7'b0, 3'b0, 0);
        step();
        step();
        drive(1, 7'b1101111, 3'b000, 0);
        step();
        c = cyc;
        pipe_en  = 1'b0;
        flush_ex = 1'b1;
        drive(1, 7'b0010011, 3'b000, 0);
        for (int k = 0; k < 4; k++) begin
            expect_at(c + k, S_PC, 1, "frz_pcsrc");
            expect_at(c + k, S_WB_RES, 1, "frz_wb_res");
            expect_at(c + k, S_WB_WR, 1, "frz_wb_wr");
        end
        step();
        step();
        step();
        pipe_en  = 1'b1;
        flush_ex = 1'b0;
        drive(0, 7'b0, 3'b0, 0);
        expect_at(c + 4, S_PC, 0, "thaw_pcsrc");
        expect_at(c + 4, S_MEM_RES, 2, "thaw_jal_mem");
        expect_at(c + 4, S_WB_RES, 0, "thaw_wb");
        step();
        step();
        step();
        step();

        // async reset with a frozen store sitting in MEM
        drive(1, 7'b0100011, 3'b010, 0);
        expect_at(cyc, S_IMD, 1, "sw_imd");
        step();
        drive(0, 7'b0, 3'b0, 0);
        expect_at(cyc, S_EX_B, 1, "sw_ex_b");
        step();
        pipe_en = 1'b0;
        expect_at(cyc, S_MEM_WR, 1, "sw_mem_wr");
        expect_at(cyc, S_MEM_F3, 2, "sw_mem_f3");
        step();
        rst_n = 1'b0;
        expect_at(cyc, S_MEM_WR, 0, "rst_mem_wr");
        expect_at(cyc, S_ALL, 0, "rst_all");
        step();
        expect_at(cyc, S_ALL, 0, "rst_hold_all");
        step();
        rst_n   = 1'b1;
        pipe_en = 1'b1;
        expect_at(cyc, S_ALL, 0, "rel_all");
        expect_at(cyc + 1, S_ALL, 0, "rel_edge_all");
        step();
        drive(1, 7'b0110011, 3'b000, 1);
        expect_at(cyc + 1, S_EX_WR, 1, "post_rst_sub_wr");
        expect_at(cyc + 1, S_EX_ALU, 1, "post_rst_sub_alu");
        expect_at(cyc + 1, S_MEM_WR, 0, "post_rst_memwr");
        step();
        drive(0, 7'b0, 3'b0, 0);
        repeat (4) step();

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors += sb.size();
            checks += sb.size();
            $display("FAIL scoreboard_drain: %0d pending, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
